xfer_gearbox: RTL and testbench

- Parametrised bit-granular width converter; next generation of the team's rx/tx bit-accumulator buffer.
- Accepts words of run-time-selectable width on a valid/ready input and emits words of independently selectable width on a valid/ready output.
- Adds back-pressure, bit-order mode, flush with zero padding, last-word marker and synchronous clear.
- Sits between serial/PHY-side shifters and bus-side packers (UART/SPI/I2S framing paths).

---
 rtl/xfer_gearbox.sv | 169 ++++++++++++++++
 tb/tb_xfer_gearbox.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfer_gearbox.sv
// -----------------------------------------------------------------------------
// xfer_gearbox
//   Bit-granular width converter between a valid/ready input of run-time width
//   rwd = min(rmsb,RMSB)+1 and a valid/ready output of run-time width
//   twd = min(tmsb,TMSB)+1. Bits are held in a CAP = 2^(AMSB+1) bit store in
//   arrival order (index 0 = oldest). A flush request drains the residue as a
//   zero-padded final word marked with tlast.
//
// Ports
//   clk, rstb      clock (rising edge), asynchronous active-low reset
//   clr            synchronous clear (same effect as reset)
//   rx/rmsb        input word (right-aligned) and its width minus 1
//   rvalid/rready  input handshake
//   tx/tmsb        output word (right-aligned, zero above tmsb) and width minus 1
//   tvalid/tready  output handshake
//   tlast          tx is the final, padded word of a flush
//   flush          one-cycle request to drain the residue
//   cnt            stored bit count 0..CAP
//   empty/full     cnt==0 / cnt==CAP
// -----------------------------------------------------------------------------
module xfer_gearbox #(
  parameter int RMSB      = 31,
  parameter int TMSB      = 31,
  parameter int AMSB      = 6,
  parameter int LSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            clr,
  input  logic [RMSB:0]   rx,
  input  logic [AMSB:0]   rmsb,
  input  logic            rvalid,
  output logic            rready,
  output logic [TMSB:0]   tx,
  input  logic [AMSB:0]   tmsb,
  output logic            tvalid,
  input  logic            tready,
  output logic            tlast,
  input  logic            flush,
  output logic [AMSB+1:0] cnt,
  output logic            empty,
  output logic            full
);

  localparam int CAP = 2 ** (AMSB + 1);
  localparam int AW  = AMSB + 3;

  typedef logic [AW-1:0] ar_t;
  localparam ar_t CAP_A = ar_t'(CAP);

  typedef enum logic {S_IDLE, S_DRAIN} st_t;

  st_t              r_st;
  st_t              w_st_nx;
  logic [AMSB+1:0]  r_cnt;
  logic [CAP-1:0]   r_buf;

  ar_t              w_rwd;
  ar_t              w_twd;
  ar_t              w_cnt_a;
  ar_t              w_take;
  ar_t              w_base;
  ar_t              w_cnt_nx;
  logic             w_fpend;
  logic             w_rready;
  logic             w_tvalid;
  logic             w_tlast;
  logic             w_push;
  logic             w_pop;
  logic [RMSB:0]    w_rx_ord;
  logic [TMSB:0]    w_tw;
  logic [CAP-1:0]   w_buf_pop;
  logic [CAP-1:0]   w_keep;
  logic [CAP-1:0]   w_ins;
  logic [CAP-1:0]   w_buf_nx;

  // Effective widths, clamped to the port maxima.
  assign w_rwd = (ar_t'(rmsb) > ar_t'(RMSB)) ? ar_t'(RMSB + 1) : ar_t'(rmsb) + ar_t'(1);
  assign w_twd = (ar_t'(tmsb) > ar_t'(TMSB)) ? ar_t'(TMSB + 1) : ar_t'(tmsb) + ar_t'(1);

  assign w_cnt_a  = ar_t'(r_cnt);
  assign w_fpend  = (r_st == S_DRAIN);
  assign w_rready = ~w_fpend & ((w_cnt_a + w_rwd) <= CAP_A);
  assign w_tvalid = (w_cnt_a >= w_twd) | (w_fpend & (r_cnt != '0));
  assign w_tlast  = w_fpend & (r_cnt != '0) & (w_cnt_a <= w_twd);
  assign w_take   = (w_cnt_a < w_twd) ? w_cnt_a : w_twd;
  assign w_push   = rvalid & w_rready;
  assign w_pop    = w_tvalid & tready;

  assign w_cnt_nx = w_cnt_a + (w_push ? w_rwd : ar_t'(0)) - (w_pop ? w_take : ar_t'(0));

  // Input word rearranged so that bit 0 is the earliest bit and bits at or
  // above rwd are zero.
  if (LSB_FIRST != 0) begin : g_rx_lsb
    assign w_rx_ord = rx & ~({(RMSB+1){1'b1}} << w_rwd);
  end else begin : g_rx_msb
    logic [RMSB:0] w_rx_rev;
    always_comb begin
      w_rx_rev = '0;
      for (int i = 0; i <= RMSB; i++) w_rx_rev[i] = rx[RMSB-i];
    end
    // Shifting the reversed word down also discards the bits above rmsb.
    assign w_rx_ord = w_rx_rev >> (ar_t'(RMSB + 1) - w_rwd);
  end

  // Store update: drop the popped bits from the bottom, then append the pushed
  // bits directly above the surviving ones. Stale bits above cnt are masked.
  assign w_buf_pop = w_pop ? (r_buf >> w_take) : r_buf;
  assign w_base    = w_cnt_a - (w_pop ? w_take : ar_t'(0));
  assign w_keep    = ~({CAP{1'b1}} << w_base);
  assign w_ins     = {{(CAP-RMSB-1){1'b0}}, w_rx_ord} << w_base;
  assign w_buf_nx  = w_push ? ((w_buf_pop & w_keep) | w_ins) : w_buf_pop;

  // Oldest min(twd,cnt) bits; everything else zero so padding comes for free.
  assign w_tw = r_buf[TMSB:0] & ~({(TMSB+1){1'b1}} << w_take);

  if (LSB_FIRST != 0) begin : g_tx_lsb
    assign tx = w_tw;
  end else begin : g_tx_msb
    logic [TMSB:0] w_tw_rev;
    always_comb begin
      w_tw_rev = '0;
      for (int i = 0; i <= TMSB; i++) w_tw_rev[i] = w_tw[TMSB-i];
    end
    // Oldest bit lands on tx[twd-1]; a short residue stays left-justified.
    assign tx = w_tw_rev >> (ar_t'(TMSB + 1) - w_twd);
  end

  // Flush FSM. Entering DRAIN requires bits to remain after this cycle,
  // otherwise there would be no final word to carry tlast.
  always_comb begin
    w_st_nx = r_st;
    case (r_st)
      S_IDLE: begin
        if (flush && (w_cnt_nx != '0)) w_st_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if ((w_pop && w_tlast) || (r_cnt == '0)) w_st_nx = S_IDLE;
      end
      default: w_st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt <= '0;
      r_st  <= S_IDLE;
    end else if (clr) begin
      r_cnt <= '0;
      r_st  <= S_IDLE;
    end else begin
      r_cnt <= w_cnt_nx[AMSB+1:0];
      r_st  <= w_st_nx;
    end
  end

  // Bit store carries no reset; only bits below cnt are ever observed.
  always_ff @(posedge clk) begin
    r_buf <= w_buf_nx;
  end

  assign rready = w_rready;
  assign tvalid = w_tvalid;
  assign tlast  = w_tlast;
  assign cnt    = r_cnt;
  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AMSB+2)'(CAP));

endmodule

// File: tb/tb_xfer_gearbox.sv
// -----------------------------------------------------------------------------
// tb_xfer_gearbox
//   Drives one MSB-first and one LSB-first gearbox with identical stimulus and
//   compares both against bit-queue reference models every cycle, plus a set of
//   hand-computed literal expectations from directed sequences.
// -----------------------------------------------------------------------------
module tb_xfer_gearbox;

  localparam int CAP = 128;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] rx = '0;
  logic [6:0]  rmsb = '0;
  logic [6:0]  tmsb = '0;
  logic        rvalid = 1'b0;
  logic        tready = 1'b0;
  logic        flush = 1'b0;

  logic        rready_m, tvalid_m, tlast_m, empty_m, full_m;
  logic [31:0] tx_m;
  logic [7:0]  cnt_m;
  logic        rready_l, tvalid_l, tlast_l, empty_l, full_l;
  logic [31:0] tx_l;
  logic [7:0]  cnt_l;

  xfer_gearbox #(.RMSB(31), .TMSB(31), .AMSB(6), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rstb(rstb), .clr(clr), .rx(rx), .rmsb(rmsb), .rvalid(rvalid),
    .rready(rready_m), .tx(tx_m), .tmsb(tmsb), .tvalid(tvalid_m), .tready(tready),
    .tlast(tlast_m), .flush(flush), .cnt(cnt_m), .empty(empty_m), .full(full_m)
  );

  xfer_gearbox #(.RMSB(31), .TMSB(31), .AMSB(6), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rstb(rstb), .clr(clr), .rx(rx), .rmsb(rmsb), .rvalid(rvalid),
    .rready(rready_l), .tx(tx_l), .tmsb(tmsb), .tvalid(tvalid_l), .tready(tready),
    .tlast(tlast_l), .flush(flush), .cnt(cnt_l), .empty(empty_l), .full(full_l)
  );

  always #5 clk = ~clk;

  // Reference state: stored bits in arrival order, oldest at index 0.
  bit qm[$];
  bit ql[$];
  bit fp = 1'b0;

  int total = 0;
  int bad   = 0;

  // Literal expectations requested by the directed sequences for this cycle.
  logic        lit_txm_en = 1'b0, lit_txl_en = 1'b0, lit_cnt_en = 1'b0;
  logic        lit_last_en = 1'b0, lit_rdy_en = 1'b0;
  logic [31:0] lit_txm = '0, lit_txl = '0;
  logic [7:0]  lit_cnt = '0;
  logic        lit_last = 1'b0, lit_rdy = 1'b0;

  function automatic int width_of(input logic [6:0] msb);
    return (int'(msb) > 31) ? 32 : int'(msb) + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: outputs are sampled mid-cycle, inputs are already stable.
  always @(negedge clk) begin
    int n, rw, tw, k;
    logic [31:0] em, el;
    logic er, ev, et;
    em = '0; el = '0;
    if (!rstb) begin
      n = 0; er = 1'b1; ev = 1'b0; et = 1'b0;
    end else begin
      n  = qm.size();
      rw = width_of(rmsb);
      tw = width_of(tmsb);
      er = !fp && (n + rw <= CAP);
      ev = (n >= tw) || (fp && n != 0);
      et = fp && n != 0 && n <= tw;
      k  = 0;
      while (k < tw && k < n) begin
        em[tw-1-k] = qm[k];
        el[k]      = ql[k];
        k++;
      end
    end
    chk("rready_m", 32'(rready_m), 32'(er));
    chk("tvalid_m", 32'(tvalid_m), 32'(ev));
    chk("tlast_m",  32'(tlast_m),  32'(et));
    chk("cnt_m",    32'(cnt_m),    32'(n));
    chk("empty_m",  32'(empty_m),  32'(n == 0));
    chk("full_m",   32'(full_m),   32'(n == CAP));
    chk("tx_m",     tx_m,          em);
    chk("rready_l", 32'(rready_l), 32'(er));
    chk("tvalid_l", 32'(tvalid_l), 32'(ev));
    chk("tlast_l",  32'(tlast_l),  32'(et));
    chk("cnt_l",    32'(cnt_l),    32'(n));
    chk("tx_l",     tx_l,          el);
    if (lit_txm_en)  chk("lit_tx_m",  tx_m,           lit_txm);
    if (lit_txl_en)  chk("lit_tx_l",  tx_l,           lit_txl);
    if (lit_cnt_en)  chk("lit_cnt",   32'(cnt_m),     32'(lit_cnt));
    if (lit_last_en) chk("lit_tlast", 32'(tlast_m),   32'(lit_last));
    if (lit_rdy_en)  chk("lit_rready",32'(rready_m),  32'(lit_rdy));
  end

  // Reference model update at each active edge, from pre-edge inputs and state.
  task automatic model_step();
    int n, rw, tw, take;
    bit rdy, vld, last, push, pop;
    if (!rstb || clr) begin
      qm.delete(); ql.delete(); fp = 1'b0;
      return;
    end
    n    = qm.size();
    rw   = width_of(rmsb);
    tw   = width_of(tmsb);
    rdy  = !fp && (n + rw <= CAP);
    vld  = (n >= tw) || (fp && n != 0);
    last = fp && n != 0 && n <= tw;
    push = rvalid && rdy;
    pop  = vld && tready;
    take = (n < tw) ? n : tw;
    if (pop) begin
      for (int j = 0; j < take; j++) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
    end
    if (push) begin
      for (int j = 0; j < rw; j++) begin
        qm.push_back(rx[rw-1-j]);
        ql.push_back(rx[j]);
      end
    end
    if (!fp) begin
      if (flush && qm.size() != 0) fp = 1'b1;
    end else if ((pop && last) || qm.size() == 0) begin
      fp = 1'b0;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic drv(input logic rv, input logic [31:0] d, input int rm,
                     input logic tr, input int tm, input logic fl);
    rvalid = rv; rx = d; rmsb = 7'(rm); tready = tr; tmsb = 7'(tm); flush = fl;
    clr = 1'b0;
    lit_txm_en = 1'b0; lit_txl_en = 1'b0; lit_cnt_en = 1'b0;
    lit_last_en = 1'b0; lit_rdy_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want_cnt(input int v);
    lit_cnt_en = 1'b1; lit_cnt = 8'(v);
  endtask

  task automatic want_rdy(input logic v);
    lit_rdy_en = 1'b1; lit_rdy = v;
  endtask

  task automatic want_tx(input logic [31:0] m, input logic [31:0] l);
    lit_txm_en = 1'b1; lit_txm = m;
    lit_txl_en = 1'b1; lit_txl = l;
  endtask

  logic [7:0]  b1 [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [31:0] e2m[4] = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
  logic [31:0] e2l[4] = '{32'hDD, 32'hCC, 32'hBB, 32'hAA};
  logic [31:0] b4 [3] = '{32'h1F, 32'h00, 32'h15};

  initial begin
    // Reset held over two edges; reset outputs pinned as well.
    drv(1'b0, '0, 7, 1'b0, 31, 1'b0);
    want_cnt(0); want_rdy(1'b1);
    tick(); tick();
    rstb = 1'b1;

    // 8-bit in, 32-bit out.
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'(b1[i]), 7, 1'b1, 31, 1'b0);
      tick();
    end
    drv(1'b0, '0, 7, 1'b1, 31, 1'b0);
    want_tx(32'h12345678, 32'h78563412); want_cnt(32);
    tick();
    drv(1'b0, '0, 7, 1'b1, 31, 1'b0);
    want_cnt(0);
    tick();

    // 32-bit in, 8-bit out.
    drv(1'b1, 32'hAABBCCDD, 31, 1'b0, 7, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, '0, 31, 1'b1, 7, 1'b0);
      want_tx(e2m[i], e2l[i]);
      tick();
    end
    drv(1'b0, '0, 31, 1'b0, 7, 1'b0);
    want_cnt(0);
    tick();

    // Fill to capacity with no consumer; the fifth word waits.
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, $urandom, 31, 1'b0, 31, 1'b0);
      if (i == 4) begin want_cnt(128); want_rdy(1'b0); end
      tick();
    end
    drv(1'b1, $urandom, 31, 1'b1, 31, 1'b0);
    want_rdy(1'b0);
    tick();
    drv(1'b1, $urandom, 31, 1'b0, 31, 1'b0);
    want_rdy(1'b1); want_cnt(96);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, '0, 31, 1'b1, 31, 1'b0);
      tick();
    end
    drv(1'b0, '0, 31, 1'b0, 31, 1'b0);
    want_cnt(0);
    tick();

    // 5-bit in, 8-bit out, then flush. Bits: 11111 00000 10101.
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, b4[i], 4, 1'b0, 7, 1'b0);
      tick();
    end
    drv(1'b0, '0, 4, 1'b0, 7, 1'b1);
    tick();
    drv(1'b1, 32'h1F, 4, 1'b1, 7, 1'b0);
    want_tx(32'hF8, 32'h1F); want_cnt(15); want_rdy(1'b0);
    lit_last_en = 1'b1; lit_last = 1'b0;
    tick();
    // Residue 0010101 left-justified -> 0x2A; LSB-first residue -> 0x54.
    drv(1'b1, 32'h1F, 4, 1'b1, 7, 1'b0);
    want_tx(32'h2A, 32'h54); want_cnt(7); want_rdy(1'b0);
    lit_last_en = 1'b1; lit_last = 1'b1;
    tick();
    drv(1'b0, '0, 7, 1'b0, 7, 1'b0);
    want_cnt(0); want_rdy(1'b1);
    tick();

    // Simultaneous push and pop of bytes at cnt=8.
    drv(1'b1, $urandom, 7, 1'b0, 7, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, $urandom, 7, 1'b1, 7, 1'b0);
      want_cnt(8);
      tick();
    end
    drv(1'b0, '0, 7, 1'b1, 7, 1'b0);
    want_cnt(8);
    tick();
    drv(1'b0, '0, 7, 1'b0, 7, 1'b0);
    want_cnt(0);
    tick();

    // Asynchronous reset during DRAIN with 13 bits stored.
    drv(1'b1, $urandom, 12, 1'b0, 31, 1'b0);
    tick();
    drv(1'b0, '0, 12, 1'b0, 31, 1'b1);
    tick();
    drv(1'b0, '0, 12, 1'b0, 31, 1'b0);
    want_cnt(13); want_rdy(1'b0); lit_last_en = 1'b1; lit_last = 1'b1;
    tick();
    rstb = 1'b0;
    drv(1'b0, '0, 12, 1'b0, 31, 1'b0);
    want_cnt(0); want_rdy(1'b1); lit_last_en = 1'b1; lit_last = 1'b0;
    tick();
    rstb = 1'b1;
    drv(1'b0, '0, 12, 1'b0, 31, 1'b0);
    want_cnt(0); want_rdy(1'b1);
    tick();

    // Synchronous clear during DRAIN with 13 bits stored.
    drv(1'b1, $urandom, 12, 1'b0, 31, 1'b0);
    tick();
    drv(1'b0, '0, 12, 1'b0, 31, 1'b1);
    tick();
    drv(1'b1, $urandom, 12, 1'b1, 31, 1'b1);
    clr = 1'b1;
    want_cnt(13); want_rdy(1'b0);
    tick();
    drv(1'b0, '0, 12, 1'b0, 31, 1'b0);
    want_cnt(0); want_rdy(1'b1); lit_last_en = 1'b1; lit_last = 1'b0;
    tick();

    // Randomized traffic with width changes, clamping, flushes and clears.
    for (int i = 0; i < 4000; i++) begin
      drv(1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 31)),
          1'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 31)),
          1'($urandom_range(0, 15) == 0));
      clr = 1'($urandom_range(0, 255) == 0);
      tick();
    end

    drv(1'b0, '0, 7, 1'b0, 7, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
